dm_responder: RTL

- Data-memory responder for the CPU's load/store port; it is the memory-side end of the CPU's data request interface.
- Accepts single-word, halfword or byte transactions over a Req/Ready handshake with a configurable number of wait states.
- Applies byte-enable writes, returns full read words, and flags illegal accesses.
- Used by the multi-cycle and pipelined CPU benches in place of the zero-latency data memory.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/dm_byte_ram.sv | 30 +++
 rtl/dm_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and byte-enable legality helper for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH_LOG2  = 12;
    localparam int DEF_WAIT_CYCLES = 2;

    // Legal byte-enable patterns: single bytes, aligned halfwords, full word.
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // True when be is one of the legal patterns and its lowest set lane
    // matches the byte offset of the address.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] lane);
        case (be)
            BE_B0:   return lane == 2'd0;
            BE_B1:   return lane == 2'd1;
            BE_B2:   return lane == 2'd2;
            BE_B3:   return lane == 2'd3;
            BE_H0:   return lane == 2'd0;
            BE_H1:   return lane == 2'd2;
            BE_W:    return lane == 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// rtl/dm_byte_ram.sv - 2^DEPTH_LOG2 x 32 RAM with per-lane write enables and registered read
// Ports: clk; re (load read strobe); we[3:0] (lane write enables); addr (word index);
//        wdata (lane-aligned store data); rdata (registered read word, holds when re=0).
module dm_byte_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder for the CPU load/store port with configurable wait states
// Ports: Clk; Reset (async, active low); Req/We/Addr/BE/WData request inputs;
//        Ready (one-cycle completion), RData (read word), Err (illegal access), Busy (Req ignored).
module dm_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [3:0]  BE,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic [31:0] RData,
    output logic        Err,
    output logic        Busy
);

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        rd_zero;   // forces RData to 0 after reset or an illegal access

    // With no wait states the commit happens on the accepting edge, so the
    // live request fields are used instead of the latched copies.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    logic [31:0] off;
    logic        legal;
    logic        accept;
    logic        enter_resp;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic        unused_off_lsb;

    assign cur_we    = (WAIT_CYCLES == 0) ? We    : we_q;
    assign cur_addr  = (WAIT_CYCLES == 0) ? Addr  : addr_q;
    assign cur_be    = (WAIT_CYCLES == 0) ? BE    : be_q;
    assign cur_wdata = (WAIT_CYCLES == 0) ? WData : wdata_q;

    // Wrapping subtraction: addresses below BASE_ADDR land far out of range.
    assign off   = cur_addr - BASE_ADDR;
    assign legal = ((off >> (DEPTH_LOG2 + 2)) == 32'd0) && be_legal(cur_be, cur_addr[1:0]);
    assign unused_off_lsb = &{1'b0, off[1:0]};

    assign accept     = Req && (state != WAIT);
    assign enter_resp = ((state == WAIT) && (cnt == 4'd0)) || ((WAIT_CYCLES == 0) && accept);

    assign ram_we = (enter_resp && cur_we && legal) ? cur_be : 4'b0000;
    assign ram_re = enter_resp && !cur_we && legal;

    dm_byte_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (Clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (off[DEPTH_LOG2+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (Req) begin
                        we_q    <= We;
                        addr_q  <= Addr;
                        be_q    <= BE;
                        wdata_q <= WData;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                err_q <= !legal;
                if (!legal) begin
                    rd_zero <= 1'b1;
                end else if (!cur_we) begin
                    rd_zero <= 1'b0;
                end
            end
        end
    end

    assign Ready = (state == RESP);
    assign Err   = (state == RESP) && err_q;
    assign Busy  = (state == WAIT);
    assign RData = rd_zero ? 32'd0 : ram_rdata;

endmodule
